// File: rtl/jt900h_div.sv
// Iterative DIV/DIVS unit for the JT900H core.
// Byte form: 16/8 bits, word form: 32/16 bits. Restoring division, one quotient bit per cen cycle.
// Result format matches the ALU write-back: quotient low, remainder high, we gives write width.
module jt900h_div (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        start,
  input  logic        sgn,
  input  logic [2:0]  w,
  input  logic [31:0] op0,
  input  logic [15:0] op1,
  output logic        busy,
  output logic        done,
  output logic [2:0]  we,
  output logic [31:0] dout,
  output logic        ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  st;
  logic [4:0]  cnt;
  logic        wide, sgn_q, neg_q, neg_r, ovf_mark;
  logic [31:0] acc, raw;
  logic [15:0] dvs;

  // Operand decode and magnitude extraction at start
  logic        legal, in_wide, a_neg, b_neg, early;
  logic [31:0] a_mag, raw_in;
  logic [15:0] b_mag, a_hi;

  // Magnitudes and early overflow / divide-by-zero detection for the incoming operands
  always_comb begin
    legal   = (w == 3'b001) || (w == 3'b010);
    in_wide = (w == 3'b010);
    a_neg   = sgn & (in_wide ? op0[31] : op0[15]);
    b_neg   = sgn & (in_wide ? op1[15] : op1[7]);
    a_mag   = {16'd0, op0[15:0]};
    b_mag   = {8'd0, op1[7:0]};
    raw_in  = {16'd0, op0[15:0]};
    if (in_wide) begin
      a_mag  = a_neg ? -op0 : op0;
      b_mag  = b_neg ? -op1 : op1;
      raw_in = op0;
    end else begin
      if (a_neg) a_mag = {16'd0, -op0[15:0]};
      if (b_neg) b_mag = {8'd0, -op1[7:0]};
    end
    a_hi  = in_wide ? a_mag[31:16] : {8'd0, a_mag[15:8]};
    // Quotient would not fit in n bits: skip the iterations entirely
    early = (b_mag == 16'd0) || (a_hi >= b_mag);
  end

  // One restoring step: upper n+1 bits of the shifted partial remainder versus the divisor
  logic [16:0] trial, diff;
  logic [15:0] upper;
  logic        qbit;
  logic [31:0] acc_nx;

  // Next partial remainder/quotient for the current iteration
  always_comb begin
    trial  = wide ? acc[31:15] : {8'd0, acc[15:7]};
    diff   = trial - {1'b0, dvs};
    qbit   = trial >= {1'b0, dvs};
    upper  = qbit ? diff[15:0] : trial[15:0];
    acc_nx = wide ? {upper, acc[14:0], qbit} : {16'd0, upper[7:0], acc[6:0], qbit};
  end

  // Sign fix-up and signed range check on the finished magnitudes
  logic [15:0] q_mag, r_mag, lim, quo, rem;
  logic        s_ovf;
  logic [31:0] res;

  // Final quotient/remainder with signs applied, plus signed overflow
  always_comb begin
    q_mag = wide ? acc[15:0]  : {8'd0, acc[7:0]};
    r_mag = wide ? acc[31:16] : {8'd0, acc[15:8]};
    lim   = wide ? 16'h8000 : 16'h0080;
    // Negative results may reach -2^(n-1); positive ones stop at 2^(n-1)-1
    s_ovf = sgn_q & (neg_q ? (q_mag > lim) : (q_mag > lim - 16'd1));
    quo   = neg_q ? -q_mag : q_mag;
    rem   = neg_r ? -r_mag : r_mag;
    res   = wide ? {rem, quo} : {16'd0, rem[7:0], quo[7:0]};
  end

  assign busy = (st != IDLE);

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= 5'd0;
      wide     <= 1'b0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_mark <= 1'b0;
      acc      <= 32'd0;
      raw      <= 32'd0;
      dvs      <= 16'd0;
      done     <= 1'b0;
      we       <= 3'b000;
      dout     <= 32'd0;
      ovf      <= 1'b0;
    end else if (cen) begin
      done <= 1'b0;
      we   <= 3'b000;
      unique case (st)
        IDLE: begin
          if (start && legal) begin
            wide     <= in_wide;
            sgn_q    <= sgn;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            ovf_mark <= early;
            acc      <= a_mag;
            dvs      <= b_mag;
            raw      <= raw_in;
            cnt      <= 5'd0;
            st       <= early ? FIX : RUN;
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + 5'd1;
          if (cnt == (wide ? 5'd15 : 5'd7)) st <= FIX;
        end
        FIX: begin
          done <= 1'b1;
          we   <= wide ? 3'b100 : 3'b010;
          if (ovf_mark || s_ovf) begin
            dout <= raw;
            ovf  <= 1'b1;
          end else begin
            dout <= res;
            ovf  <= 1'b0;
          end
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_div.sv
// Self-checking bench for jt900h_div: directed cases plus random operands against an
// arithmetic reference model.
module tb_jt900h_div;

  logic        rst, clk, cen, start, sgn;
  logic [2:0]  w;
  logic [31:0] op0;
  logic [15:0] op1;
  logic        busy, done, ovf;
  logic [2:0]  we;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;

  jt900h_div dut (
    .rst   (rst),
    .clk   (clk),
    .cen   (cen),
    .start (start),
    .sgn   (sgn),
    .w     (w),
    .op0   (op0),
    .op1   (op1),
    .busy  (busy),
    .done  (done),
    .we    (we),
    .dout  (dout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; lat counts enabled edges after the start edge
  task automatic model(input bit s, input bit wide, input logic [31:0] a, input logic [15:0] b,
                       output logic [31:0] d, output bit v, output int lat);
    int     n;
    longint da, db, ma, mb, q, r, mask;
    logic [31:0] raw;
    n    = wide ? 16 : 8;
    mask = (64'sd1 <<< n) - 1;
    raw  = wide ? a : {16'd0, a[15:0]};
    if (s) begin
      da = wide ? longint'($signed(a)) : longint'($signed(a[15:0]));
      db = wide ? longint'($signed(b)) : longint'($signed(b[7:0]));
    end else begin
      da = wide ? longint'(a) : longint'(a[15:0]);
      db = wide ? longint'(b) : longint'(b[7:0]);
    end
    ma = (da < 0) ? -da : da;
    mb = (db < 0) ? -db : db;
    if (mb == 0 || (ma / mb) >= (64'sd1 <<< n)) begin
      d = raw; v = 1'b1; lat = 1;
    end else begin
      q   = da / db;
      r   = da % db;
      lat = n + 1;
      if (s && (q > (64'sd1 <<< (n - 1)) - 1 || q < -(64'sd1 <<< (n - 1)))) begin
        d = raw; v = 1'b1;
      end else begin
        d = 32'(((r & mask) << n) | (q & mask));
        v = 1'b0;
      end
    end
  endtask

  // One division; optional 50% cen and a disturbing start pulse mid-run
  task automatic run(input bit s, input logic [2:0] ww, input logic [31:0] a,
                     input logic [15:0] b, input bit toggle, input bit restart);
    logic [31:0] ed;
    bit          ev, seen, en;
    int          lat, edges, clks;
    model(s, ww == 3'b010, a, b, ed, ev, lat);
    @(negedge clk);
    cen = 1'b1; start = 1'b1; sgn = s; w = ww; op0 = a; op1 = b;
    @(posedge clk); #1;
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_low_after_start", 32'(done), 32'd0);
    edges = 0; clks = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      sgn = ~s; op0 = $urandom; op1 = 16'($urandom); w = 3'($urandom);
      cen = toggle ? ~cen : 1'b1;
      if (restart && edges == 3 && cen) begin
        start = 1'b1; w = 3'b001;
      end
      @(posedge clk); en = cen; #1;
      clks++;
      if (en) edges++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", edges, lat);
    if (toggle) check("latency_clk", clks, 2 * lat);
    check("dout", dout, ed);
    check("ovf", 32'(ovf), 32'(ev));
    check("we", 32'(we), (ww == 3'b010) ? 32'd4 : 32'd2);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    bit          saw;
    logic [31:0] a;
    logic [15:0] b;
    logic [2:0]  ww;
    rst = 1'b1; cen = 1'b1; start = 1'b0; sgn = 1'b0; w = 3'b001; op0 = 32'd0; op1 = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(1'b0, 3'b001, 32'h0000_0064, 16'h0007, 1'b0, 1'b0);
    check("tp_ubyte", dout, 32'h0000_020E);
    run(1'b0, 3'b010, 32'h0001_0000, 16'h0003, 1'b0, 1'b0);
    check("tp_uword", dout, 32'h0001_5555);
    run(1'b0, 3'b001, 32'h0000_1234, 16'h0000, 1'b0, 1'b0);
    check("tp_div0", dout, 32'h0000_1234);
    run(1'b0, 3'b001, 32'h0000_0900, 16'h0009, 1'b0, 1'b0);
    check("tp_early", dout, 32'h0000_0900);
    run(1'b1, 3'b001, 32'h0000_FF9C, 16'h0007, 1'b0, 1'b0);
    check("tp_sbyte", dout, 32'h0000_FEF2);
    run(1'b1, 3'b001, 32'h0000_0080, 16'h0001, 1'b0, 1'b0);
    check("tp_sbyte_ovf", 32'(ovf), 32'd1);
    run(1'b1, 3'b001, 32'h0000_FF80, 16'h0001, 1'b0, 1'b0);
    check("tp_sbyte_min", dout, 32'h0000_0080);
    run(1'b1, 3'b010, 32'hFFFF_0000, 16'h0003, 1'b0, 1'b0);
    check("tp_sword", dout, 32'hFFFF_AAAB);
    run(1'b0, 3'b001, 32'h0000_0064, 16'h0007, 1'b0, 1'b1);
    check("tp_restart", dout, 32'h0000_020E);
    run(1'b1, 3'b010, 32'hFFFF_0000, 16'h0003, 1'b1, 1'b0);
    check("tp_cen_toggle", dout, 32'hFFFF_AAAB);

    // Random operands; half the time the dividend is shrunk so the quotient usually fits
    for (int i = 0; i < 40; i++) begin
      ww = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
      a  = $urandom;
      b  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(8, 24);
      run(1'($urandom), ww, a, b, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    // Illegal width: start ignored
    @(negedge clk);
    cen = 1'b1; start = 1'b1; w = 3'b011; op0 = 32'h0000_0064; op1 = 16'h0007;
    @(posedge clk); #1;
    check("illegal_w_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    check("illegal_w_no_done", 32'(saw), 32'd0);

    // Reset during iteration 5
    run(1'b0, 3'b001, 32'h0000_0064, 16'h0007, 1'b0, 1'b0);
    @(negedge clk);
    cen = 1'b1; start = 1'b1; sgn = 1'b0; w = 3'b001; op0 = 32'h0000_00C8; op1 = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dout", dout, 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_we", 32'(we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1'b1;
    end
    check("midrst_no_done", 32'(saw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
